// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage: one multiplier bit per cycle,
// stalls the front of the pipeline while busy and emits a one-cycle write request.
module ex_mul_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             RegWrite_o,
  output logic [4:0]       RDaddr_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [4:0]         rd_q;

  logic [WIDTH-1:0]   rs_mag, rt_mag, mplier_sh;
  logic [2*WIDTH-1:0] acc_nxt, product;
  logic               start_ok;

  assign start_ok  = start_i && !flush_i;
  assign rs_mag    = (signed_i && RSdata_i[WIDTH-1]) ? -RSdata_i : RSdata_i;
  assign rt_mag    = (signed_i && RTdata_i[WIDTH-1]) ? -RTdata_i : RTdata_i;
  assign mplier_sh = mplier_q >> 1;
  assign acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // Sign is applied on the final BUSY edge so results land at DONE entry.
  assign product   = neg_q ? -acc_nxt : acc_nxt;
  assign RegWrite_o = done_o;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          stall_o = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if ((count_q == CW'(1)) || ((EARLY_TERM != 0) && (mplier_sh == '0))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = !flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      rd_q        <= '0;
      RDaddr_o    <= '0;
      result_lo_o <= '0;
      result_hi_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            mcand_q  <= {{WIDTH{1'b0}}, rs_mag};
            mplier_q <= rt_mag;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
            neg_q    <= signed_i && (RSdata_i[WIDTH-1] ^ RTdata_i[WIDTH-1]);
            rd_q     <= RDaddr_i;
          end
        end
        BUSY: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_sh;
          count_q  <= count_q - CW'(1);
          if (state_d == DONE) begin
            result_lo_o <= product[WIDTH-1:0];
            result_hi_o <= product[2*WIDTH-1:WIDTH];
            RDaddr_o    <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: one instance without and one with early termination.
module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        rst, start0, start1, sgn, flush;
  logic [31:0] rs, rt;
  logic [4:0]  rd;

  logic        stall0, done0, rw0, stall1, done1, rw1;
  logic [4:0]  rdo0, rdo1;
  logic [31:0] lo0, hi0, lo1, hi1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mul_unit #(.WIDTH(32), .EARLY_TERM(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .signed_i(sgn),
    .RSdata_i(rs), .RTdata_i(rt), .RDaddr_i(rd), .flush_i(flush),
    .stall_o(stall0), .done_o(done0), .RegWrite_o(rw0), .RDaddr_o(rdo0),
    .result_lo_o(lo0), .result_hi_o(hi0)
  );

  ex_mul_unit #(.WIDTH(32), .EARLY_TERM(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .signed_i(sgn),
    .RSdata_i(rs), .RTdata_i(rt), .RDaddr_i(rd), .flush_i(flush),
    .stall_o(stall1), .done_o(done1), .RegWrite_o(rw1), .RDaddr_o(rdo1),
    .result_lo_o(lo1), .result_hi_o(hi1)
  );

  task automatic sample(input bit sel, output logic st, output logic dn, output logic rw,
                        output logic [4:0] ro, output logic [31:0] lo, output logic [31:0] hi);
    st = sel ? stall1 : stall0;
    dn = sel ? done1  : done0;
    rw = sel ? rw1    : rw0;
    ro = sel ? rdo1   : rdo0;
    lo = sel ? lo1    : lo0;
    hi = sel ? hi1    : hi0;
  endtask

  // Issues a multiply at the next cycle T, holds start through DONE (cycle T+lat).
  task automatic run_mul(input bit sel, input bit sgn_v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int unsigned lat, input logic [31:0] elo,
                         input logic [31:0] ehi, input string nm);
    logic st, dn, rw, edn;
    logic [4:0] ro;
    logic [31:0] lo, hi;
    @(posedge clk); #1;
    sgn = sgn_v; rs = a; rt = b; rd = r; flush = 1'b0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    #1;
    sample(sel, st, dn, rw, ro, lo, hi);
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL %s stall@T got=%b exp=1", nm, st); end
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk); #2;
      sample(sel, st, dn, rw, ro, lo, hi);
      edn = (k == lat);
      checks++;
      if (dn !== edn) begin errors++; $display("FAIL %s done@T+%0d got=%b exp=%b", nm, k, dn, edn); end
      checks++;
      if (rw !== edn) begin errors++; $display("FAIL %s regwrite@T+%0d got=%b exp=%b", nm, k, rw, edn); end
      checks++;
      if (st !== (k < lat)) begin errors++; $display("FAIL %s stall@T+%0d got=%b exp=%b", nm, k, st, (k < lat)); end
      if (k == lat) begin
        checks++;
        if (lo !== elo) begin errors++; $display("FAIL %s lo got=%h exp=%h", nm, lo, elo); end
        checks++;
        if (hi !== ehi) begin errors++; $display("FAIL %s hi got=%h exp=%h", nm, hi, ehi); end
        checks++;
        if (ro !== r) begin errors++; $display("FAIL %s rdaddr got=%0d exp=%0d", nm, ro, r); end
      end
    end
  endtask

  task automatic idle_after(input bit sel, input string nm);
    logic st, dn, rw;
    logic [4:0] ro;
    logic [31:0] lo, hi;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    #1;
    sample(sel, st, dn, rw, ro, lo, hi);
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL %s idle_stall got=%b exp=0", nm, st); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL %s idle_done got=%b exp=0", nm, dn); end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({stall0, done0, rw0, rdo0, lo0, hi0} !== '0)
      begin errors++; $display("FAIL %s dut0 st=%b dn=%b rw=%b rd=%0d lo=%h hi=%h exp all 0", nm, stall0, done0, rw0, rdo0, lo0, hi0); end
    checks++;
    if ({stall1, done1, rw1, rdo1, lo1, hi1} !== '0)
      begin errors++; $display("FAIL %s dut1 st=%b dn=%b rw=%b rd=%0d lo=%h hi=%h exp all 0", nm, stall1, done1, rw1, rdo1, lo1, hi1); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    check_zero("reset");
  endtask

  task automatic test_unsigned_full();
    run_mul(0, 0, 32'd7, 32'd6, 5'd5, 33, 32'd42, 32'd0, "u7x6");
    idle_after(0, "u7x6");
  endtask

  task automatic test_signed();
    run_mul(0, 1, 32'hFFFF_FFFD, 32'd5, 5'd6, 33, 32'hFFFF_FFF1, 32'hFFFF_FFFF, "s_m3x5");
    idle_after(0, "s_m3x5");
    run_mul(0, 1, 32'h8000_0000, 32'h8000_0000, 5'd7, 33, 32'h0, 32'h4000_0000, "s_minsq");
    idle_after(0, "s_minsq");
    run_mul(1, 1, 32'hFFFF_FFFD, 32'd5, 5'd8, 4, 32'hFFFF_FFF1, 32'hFFFF_FFFF, "et_m3x5");
    idle_after(1, "et_m3x5");
    run_mul(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 33, 32'h0000_0001, 32'hFFFF_FFFE, "et_maxsq");
    idle_after(1, "et_maxsq");
  endtask

  task automatic test_early_term();
    run_mul(1, 0, 32'h1234_5678, 32'd1, 5'd10, 2, 32'h1234_5678, 32'd0, "et_rt1");
    idle_after(1, "et_rt1");
    run_mul(1, 0, 32'd9, 32'd0, 5'd11, 2, 32'd0, 32'd0, "et_rt0");
    idle_after(1, "et_rt0");
  endtask

  task automatic test_back_to_back();
    run_mul(0, 0, 32'd100, 32'd3, 5'd3, 33, 32'd300, 32'd0, "b2b_1");
    run_mul(0, 0, 32'h0001_0000, 32'h0001_0000, 5'd4, 33, 32'd0, 32'd1, "b2b_2");
    idle_after(0, "b2b_2");
  endtask

  task automatic test_flush_busy();
    int seen;
    @(posedge clk); #1;
    sgn = 1'b0; rs = 32'd7; rt = 32'd6; rd = 5'd12; start0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) flush = 1'b1;
      #1;
      checks++;
      if (stall0 !== 1'b1 || done0 !== 1'b0)
        begin errors++; $display("FAIL flush_busy T+%0d stall=%b done=%b exp 1/0", k, stall0, done0); end
    end
    @(posedge clk); #1;
    flush = 1'b0; start0 = 1'b0; #1;
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_busy stall got=%b exp=0", stall0); end
    checks++;
    if (lo0 !== 32'd0 || hi0 !== 32'd1 || rdo0 !== 5'd4)
      begin errors++; $display("FAIL flush_busy held lo=%h hi=%h rd=%0d exp 0/1/4", lo0, hi0, rdo0); end
    seen = 0;
    repeat (35) begin
      @(posedge clk); #2;
      if (done0 !== 1'b0 || stall0 !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_busy late_activity got=%0d exp=0", seen); end
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1;
    start0 = 1'b1; flush = 1'b1; #1;
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_idle stall got=%b exp=0", stall0); end
    @(posedge clk); #1;
    start0 = 1'b0; flush = 1'b0; #1;
    checks++;
    if (stall0 !== 1'b0 || done0 !== 1'b0)
      begin errors++; $display("FAIL flush_idle next stall=%b done=%b exp 0/0", stall0, done0); end
  endtask

  task automatic test_flush_done();
    @(posedge clk); #1;
    sgn = 1'b0; rs = 32'h55; rt = 32'd1; rd = 5'd13; start1 = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (stall1 !== 1'b1) begin errors++; $display("FAIL flush_done busy_stall got=%b exp=1", stall1); end
    @(posedge clk); #1;
    flush = 1'b1; #1;
    checks++;
    if (done1 !== 1'b0 || rw1 !== 1'b0)
      begin errors++; $display("FAIL flush_done pulse done=%b rw=%b exp 0/0", done1, rw1); end
    checks++;
    if (lo1 !== 32'h55 || hi1 !== 32'd0 || rdo1 !== 5'd13)
      begin errors++; $display("FAIL flush_done results lo=%h hi=%h rd=%0d exp 55/0/13", lo1, hi1, rdo1); end
    @(posedge clk); #1;
    flush = 1'b0; start1 = 1'b0; #1;
    checks++;
    if (stall1 !== 1'b0 || done1 !== 1'b0)
      begin errors++; $display("FAIL flush_done after stall=%b done=%b exp 0/0", stall1, done1); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    sgn = 1'b0; rs = 32'd7; rt = 32'd6; rd = 5'd14; start0 = 1'b1;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start0 = 1'b0; #1;
    check_zero("reset_mid");
    run_mul(0, 0, 32'd7, 32'd6, 5'd15, 33, 32'd42, 32'd0, "after_reset");
    idle_after(0, "after_reset");
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sgn = 1'b0; flush = 1'b0;
    rs = '0; rt = '0; rd = '0;
    test_reset();
    test_unsigned_full();
    test_signed();
    test_early_term();
    test_back_to_back();
    test_flush_busy();
    test_flush_idle();
    test_flush_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
